// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding logic.
// One shadow-stage entry mirrors the control bits the pipeline carries per stage.
package pipe_pkg;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   localparam logic [4:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic       valid;
      logic [4:0] dst;
      logic       reg_write;
      logic       mem_read;
      logic [4:0] rs;
      logic [4:0] rt;
      logic       uses_rt;
      logic       alu_src;
   } stage_t;

   localparam stage_t STAGE_BUBBLE = '0;

   // True when the stage will write a real register that the reader needs.
   function automatic logic stage_hits(input stage_t s, input logic [4:0] src);
      return s.reg_write && (s.dst != REG_ZERO) && (s.dst == src);
   endfunction

endpackage

// File: rtl/fwd_select.sv
// Operand forward select for one EX operand: MEM result beats WB data beats register file.
module fwd_select
   import pipe_pkg::*;
(
   input  logic [4:0] i_src,
   input  logic       i_uses,
   input  stage_t     i_mem,
   input  stage_t     i_wb,
   output logic [1:0] o_sel
);

   logic w_unused_fields;
   assign w_unused_fields = ^{i_mem, i_wb};

   always_comb begin
      o_sel = FWD_RF;
      if (i_uses && stage_hits(i_mem, i_src)) begin
         o_sel = FWD_MEM;
      end else if (i_uses && stage_hits(i_wb, i_src)) begin
         o_sel = FWD_WB;
      end
   end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Hazard detection and forwarding control for the 5-stage pipeline.
// Keeps shadow EX/MEM/WB entries so only ID decode plus stall/branch inputs are needed.
module hazard_fwd_unit
   import pipe_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_valid,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rt,
   input  logic [4:0]       id_dst,
   input  logic             id_reg_write,
   input  logic             id_mem_read,
   input  logic             id_alu_src,
   input  logic             branch_taken,
   input  logic             ext_stall,
   output logic [1:0]       Aforward,
   output logic [1:0]       Bforward,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             idex_bubble,
   output logic             ifid_flush,
   output logic [CNT_W-1:0] stall_cnt
);

   stage_t           r_ex;
   stage_t           r_mem;
   stage_t           r_wb;
   stage_t           w_id;
   logic             w_load_use;
   logic             w_b_uses;
   logic [CNT_W-1:0] r_stall_cnt;

   always_comb begin
      w_id           = STAGE_BUBBLE;
      w_id.valid     = id_valid;
      w_id.dst       = id_dst;
      w_id.reg_write = id_valid & id_reg_write;
      w_id.mem_read  = id_valid & id_mem_read;
      w_id.rs        = id_rs;
      w_id.rt        = id_rt;
      w_id.uses_rt   = id_uses_rt;
      w_id.alu_src   = id_alu_src;
   end

   assign w_load_use = id_valid && r_ex.mem_read && (r_ex.dst != REG_ZERO) &&
                       ((r_ex.dst == id_rs) || (id_uses_rt && (r_ex.dst == id_rt)));

   // ext_stall outranks everything; a load-use stall suppresses the branch flush.
   always_comb begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      idex_bubble = 1'b0;
      ifid_flush  = 1'b0;
      if (ext_stall) begin
         pc_write   = 1'b0;
         ifid_write = 1'b0;
      end else if (w_load_use) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         idex_bubble = 1'b1;
      end else begin
         ifid_flush = branch_taken;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ex        <= STAGE_BUBBLE;
         r_mem       <= STAGE_BUBBLE;
         r_wb        <= STAGE_BUBBLE;
         r_stall_cnt <= '0;
      end else begin
         if (!pc_write && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
         end
         if (!ext_stall) begin
            r_wb  <= r_mem;
            r_mem <= r_ex;
            r_ex  <= w_load_use ? STAGE_BUBBLE : w_id;
         end
      end
   end

   // B sits behind the immediate mux, so an immediate operand is never overridden.
   assign w_b_uses = r_ex.uses_rt & ~r_ex.alu_src;

   fwd_select u_fwd_a (
      .i_src  (r_ex.rs),
      .i_uses (1'b1),
      .i_mem  (r_mem),
      .i_wb   (r_wb),
      .o_sel  (Aforward)
   );

   fwd_select u_fwd_b (
      .i_src  (r_ex.rt),
      .i_uses (w_b_uses),
      .i_mem  (r_mem),
      .i_wb   (r_wb),
      .o_sel  (Bforward)
   );

   assign stall_cnt = r_stall_cnt;

endmodule
